fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the 32x13 program memory and downstream-feeding the decoder.
- Owns the program counter and drives the memory address. The memory read is combinational, so the block captures the returned 13-bit instruction word into an instruction register.
- Presents the captured word to decode with a valid/ready handshake.
- Handles jump redirects (with flush), pause (enable low) and halt.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/program_counter.sv | 44 ++++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared CPU constants, instruction-format widths and fetch state type
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int INS_W_DEF  = 13;
  localparam int OPCODE_W   = 5;
  localparam int OPERAND_W  = 8;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP = 5'h00;
  localparam logic [OPCODE_W-1:0] OPCODE_LDA = 5'h01;
  localparam logic [OPCODE_W-1:0] OPCODE_STA = 5'h02;
  localparam logic [OPCODE_W-1:0] OPCODE_ADD = 5'h03;
  localparam logic [OPCODE_W-1:0] OPCODE_SUB = 5'h04;
  localparam logic [OPCODE_W-1:0] OPCODE_JMP = 5'h05;
  localparam logic [OPCODE_W-1:0] OPCODE_JZ  = 5'h06;
  localparam logic [OPCODE_W-1:0] OPCODE_HLT = 5'h1F;

  localparam logic [1:0] REG_SEL_A = 2'd0;
  localparam logic [1:0] REG_SEL_B = 2'd1;
  localparam logic [1:0] REG_SEL_C = 2'd2;
  localparam logic [1:0] REG_SEL_D = 2'd3;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module   : program_counter
// Purpose  : PC register with jump load, hold and modulo-2^ADDR_W increment
// Revision : 1.0
// ============================================================================
module program_counter #(
  parameter int ADDR_W = 5,
  parameter int RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_en_i,
  input  logic              ld_en_i,
  input  logic [ADDR_W-1:0] ld_val_i,
  input  logic              hold_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // A jump load wins over hold so redirects are never lost; wrap is silent.
  always_comb begin
    pc_d = pc_q;
    if (ld_en_i) begin
      pc_d = ld_val_i;
    end else if (!hold_i && inc_en_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= ADDR_W'(RST_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch: PC, instruction register, decode handshake,
//            jump flush and halt
// Revision : 1.0
// ============================================================================
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INS_W  = INS_W_DEF,
  parameter int RST_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [INS_W-1:0]  ins_in,
  output logic [INS_W-1:0]  ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              halt_req,
  output logic              halted
);

  localparam logic [INS_W-1:0] C_NOP_WORD = {OPCODE_NOP, {(INS_W-OPCODE_W){1'b0}}};

  fetch_state_t      state_q, state_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              w_load;
  logic              w_jump;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_pc;

  program_counter #(
    .ADDR_W (ADDR_W),
    .RST_PC (RST_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .inc_en_i (w_load),
    .ld_en_i  (w_jump),
    .ld_val_i (jmp_addr),
    .hold_i   (state_q == HALT),
    .pc_o     (w_pc)
  );

  assign w_xfer = ir_valid_q && ir_ready;

  // Priority inside RUN: jump, then halt, then load/transfer.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    w_load     = 1'b0;
    w_jump     = 1'b0;

    if (state_q == RUN) begin
      if (jmp_req) begin
        w_jump     = 1'b1;
        ir_valid_d = 1'b0;
      end else if (halt_req) begin
        state_d = HALT;
        if (w_xfer) begin
          ir_valid_d = 1'b0;
        end
      end else begin
        w_load = en && (!ir_valid_q || ir_ready);
        if (w_load) begin
          ir_d       = ins_in;
          ir_pc_d    = w_pc;
          ir_valid_d = 1'b1;
        end else if (w_xfer) begin
          ir_valid_d = 1'b0;
        end
      end
    end else begin
      // Only draining of an already-captured word is allowed once halted.
      if (w_xfer) begin
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      ir_q       <= C_NOP_WORD;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign pc_addr  = w_pc;
  assign ir_out   = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Scoreboard bench for fetch_unit with directed stimulus
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

  localparam int ADDR_W = 5;
  localparam int INS_W  = 13;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst, en, ir_ready, jmp_req, halt_req;
  logic [ADDR_W-1:0] jmp_addr;
  logic [ADDR_W-1:0] pc_addr;
  logic [INS_W-1:0]  ins_in;
  logic [INS_W-1:0]  ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              halted;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Program memory image: word k holds k + 0x100.
  assign ins_in = INS_W'(13'h100 + 13'(pc_addr));

  fetch_unit #(.ADDR_W(ADDR_W), .INS_W(INS_W), .RST_PC(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pc_addr  (pc_addr),
    .ins_in   (ins_in),
    .ir_out   (ir_out),
    .ir_pc    (ir_pc),
    .ir_valid (ir_valid),
    .ir_ready (ir_ready),
    .jmp_req  (jmp_req),
    .jmp_addr (jmp_addr),
    .halt_req (halt_req),
    .halted   (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a);
    exp_t e;
    e.pc  = ADDR_W'(a);
    e.ins = INS_W'(13'h100 + 13'(a));
    sb_q.push_back(e);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) push(a);
  endtask

  // Every accepted word is popped and compared against the scoreboard.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ir_valid === 1'b1 && ir_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_xfer_pc", 32'(ir_pc), 32'hFFFF_FFFF);
        end else begin
          e = sb_q.pop_front();
          chk("xfer_pc", 32'(ir_pc), 32'(e.pc));
          chk("xfer_ins", 32'(ir_out), 32'(e.ins));
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc_addr"}, 32'(pc_addr), 32'h0);
    chk({tag, "_ir_valid"}, 32'(ir_valid), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_ir_out"}, 32'(ir_out), 32'h0);
    chk({tag, "_ir_pc"}, 32'(ir_pc), 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; ir_ready = 1'b0;
    jmp_req = 1'b0; halt_req = 1'b0; jmp_addr = '0;
    fork
      monitor();
    join_none

    cyc(2);
    rst = 1'b0;
    chk_reset("reset");

    // Streaming, one word per cycle, then a 3-cycle stall at address 4.
    push_range(0, 4);
    en = 1'b1; ir_ready = 1'b1;
    cyc(1);
    chk("first_valid", 32'(ir_valid), 32'h1);
    chk("first_pc", 32'(ir_pc), 32'h0);
    cyc(4);
    chk("pre_stall_pc", 32'(ir_pc), 32'h4);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_ir_pc", 32'(ir_pc), 32'h4);
      chk("stall_pc_addr", 32'(pc_addr), 32'h5);
      chk("stall_valid", 32'(ir_valid), 32'h1);
    end
    ir_ready = 1'b1;
    push_range(5, 31);
    push_range(0, 6);
    cyc(1);
    chk("post_stall_pc", 32'(ir_pc), 32'h5);

    // Wrap 31 -> 0.
    cyc(26);
    chk("wrap31_ir_pc", 32'(ir_pc), 32'd31);
    chk("wrap31_pc_addr", 32'(pc_addr), 32'h0);
    cyc(1);
    chk("wrap0_ir_pc", 32'(ir_pc), 32'h0);
    chk("wrap0_pc_addr", 32'(pc_addr), 32'h1);
    chk("wrap0_ir_out", 32'(ir_out), 32'h100);

    // Jump flushes the wrong-path word at address 7.
    cyc(7);
    chk("prejump_ir_pc", 32'(ir_pc), 32'h7);
    jmp_req = 1'b1; jmp_addr = 5'd20; ir_ready = 1'b0;
    cyc(1);
    chk("jump_flush_valid", 32'(ir_valid), 32'h0);
    chk("jump_pc_addr", 32'(pc_addr), 32'd20);
    jmp_req = 1'b0; ir_ready = 1'b1;
    push(20);
    cyc(1);
    chk("jump_target_pc", 32'(ir_pc), 32'd20);
    chk("jump_target_valid", 32'(ir_valid), 32'h1);
    cyc(1);

    // Jump and halt together: jump wins.
    jmp_req = 1'b1; halt_req = 1'b1; jmp_addr = 5'd10; ir_ready = 1'b0;
    cyc(1);
    chk("jmphalt_halted", 32'(halted), 32'h0);
    chk("jmphalt_pc_addr", 32'(pc_addr), 32'd10);
    chk("jmphalt_valid", 32'(ir_valid), 32'h0);
    jmp_req = 1'b0; halt_req = 1'b0; ir_ready = 1'b1;
    push(10);
    cyc(2);

    // Halt with a stalled valid IR, drain, then ignore a jump.
    halt_req = 1'b1; ir_ready = 1'b0;
    push(11);
    cyc(1);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_valid", 32'(ir_valid), 32'h1);
    chk("halt_ir_pc", 32'(ir_pc), 32'd11);
    chk("halt_pc_addr", 32'(pc_addr), 32'd12);
    halt_req = 1'b0;
    cyc(2);
    chk("halt_hold_pc", 32'(ir_pc), 32'd11);
    chk("halt_hold_valid", 32'(ir_valid), 32'h1);
    ir_ready = 1'b1;
    cyc(1);
    chk("halt_drained", 32'(ir_valid), 32'h0);
    chk("halt_pc_frozen", 32'(pc_addr), 32'd12);
    jmp_req = 1'b1; jmp_addr = 5'd3;
    cyc(1);
    chk("halt_jmp_ignored", 32'(pc_addr), 32'd12);
    chk("halt_still_empty", 32'(ir_valid), 32'h0);
    chk("halt_still_halted", 32'(halted), 32'h1);
    jmp_req = 1'b0;
    cyc(1);

    // Reset from HALT, then reset in the middle of a stall.
    rst = 1'b1;
    cyc(1);
    chk_reset("rst_halt");
    rst = 1'b0; ir_ready = 1'b0;
    cyc(1);
    chk("stall2_valid", 32'(ir_valid), 32'h1);
    chk("stall2_pc_addr", 32'(pc_addr), 32'h1);
    cyc(1);
    chk("stall2_ir_pc", 32'(ir_pc), 32'h0);
    rst = 1'b1;
    cyc(1);
    chk_reset("rst_stall");
    rst = 1'b0; ir_ready = 1'b1;
    push_range(0, 1);
    cyc(2);
    chk("pause_pre_ir_pc", 32'(ir_pc), 32'h1);

    // Pause: PC holds while the IR drains on ir_ready.
    en = 1'b0; ir_ready = 1'b0;
    cyc(1);
    chk("pause_pc0", 32'(pc_addr), 32'h2);
    chk("pause_valid", 32'(ir_valid), 32'h1);
    cyc(1);
    chk("pause_pc1", 32'(pc_addr), 32'h2);
    ir_ready = 1'b1;
    cyc(1);
    chk("pause_drained", 32'(ir_valid), 32'h0);
    chk("pause_pc2", 32'(pc_addr), 32'h2);
    cyc(1);
    chk("pause_pc3", 32'(pc_addr), 32'h2);

    cyc(2);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
